// File: rtl/calc_entry_fsm_if.sv
// Keypad-side and arithmetic-unit-side signals of the operand-entry controller.
// The master modport is the environment; the slave modport is calc_entry_fsm.
interface calc_entry_fsm_if #(
  parameter int unsigned NDIGITS = 4
);
  localparam int unsigned W = 4 * NDIGITS;

  logic         key_valid;
  logic [3:0]   key;
  logic         keytype;
  logic         result_valid;
  logic [W-1:0] result_bcd;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   op;
  logic         calc_start;
  logic [W-1:0] display_bcd;
  logic [1:0]   state_dbg;

  modport master (
    output key_valid, key, keytype, result_valid, result_bcd,
    input  operand_a, operand_b, op, calc_start, display_bcd, state_dbg
  );

  modport slave (
    input  key_valid, key, keytype, result_valid, result_bcd,
    output operand_a, operand_b, op, calc_start, display_bcd, state_dbg
  );
endinterface

// File: rtl/calc_entry_fsm.sv
// Operand-entry controller: builds BCD operand A, operator and operand B from
// keypad strobes, starts the arithmetic unit and latches its result for display.
module calc_entry_fsm #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic           clock,
  input  logic           reset,
  calc_entry_fsm_if.slave bus
);
  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    WAIT_RES = 2'b10,
    SHOW     = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d;
  logic [CW-1:0]   cnt_b_q, cnt_b_d;
  logic            start_q, start_d;

  logic            is_digit, is_sym, is_op, is_eq, is_clr;
  logic [W-1:0]    digit_ext;
  logic [1:0]      key_op;

  // Keys whose keytype disagrees with the code range are treated as no key.
  always_comb begin
    is_digit  = bus.key_valid &&  bus.keytype && (bus.key <= 4'd9);
    is_sym    = bus.key_valid && !bus.keytype && (bus.key >= 4'hA);
    is_op     = is_sym && (bus.key <= 4'hD);
    is_eq     = is_sym && (bus.key == 4'hE);
    is_clr    = is_sym && (bus.key == 4'hF);
    digit_ext = W'(bus.key);
    key_op    = 2'(bus.key - 4'hA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    start_d = 1'b0;

    // Clear wins over everything, including a result arriving the same cycle.
    if (is_clr) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      op_d    = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (is_digit) begin
            if (cnt_a_q != CW'(NDIGITS)) begin
              a_d     = (a_q << 4) | digit_ext;
              cnt_a_d = cnt_a_q + CW'(1);
            end
          end else if (is_op) begin
            op_d    = key_op;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit) begin
            if (cnt_b_q != CW'(NDIGITS)) begin
              b_d     = (b_q << 4) | digit_ext;
              cnt_b_d = cnt_b_q + CW'(1);
            end
          end else if (is_op) begin
            if (cnt_b_q == '0) op_d = key_op;
          end else if (is_eq) begin
            if (cnt_b_q != '0) begin
              start_d = 1'b1;
              state_d = WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (bus.result_valid) begin
            res_d   = bus.result_bcd;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (is_digit) begin
            a_d     = digit_ext;
            cnt_a_d = CW'(1);
            b_d     = '0;
            cnt_b_d = '0;
            state_d = ENTER_A;
          end else if (is_op) begin
            // Chain the previous result as a full-width operand A.
            a_d     = res_q;
            cnt_a_d = CW'(NDIGITS);
            b_d     = '0;
            cnt_b_d = '0;
            op_d    = key_op;
            state_d = ENTER_B;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      ENTER_A:  bus.display_bcd = a_q;
      ENTER_B:  bus.display_bcd = (cnt_b_q == '0) ? a_q : b_q;
      WAIT_RES: bus.display_bcd = b_q;
      SHOW:     bus.display_bcd = res_q;
      default:  bus.display_bcd = a_q;
    endcase
  end

  assign bus.operand_a  = a_q;
  assign bus.operand_b  = b_q;
  assign bus.op         = op_q;
  assign bus.calc_start = start_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm: one-cycle vector table plus hand-written
// sequences for calc_start pulse width and result chaining.
module tb_calc_entry_fsm;
  localparam int unsigned ND = 4;
  localparam int unsigned W  = 4 * ND;

  logic clock = 1'b0;
  logic reset;

  calc_entry_fsm_if #(.NDIGITS(ND)) bus ();

  calc_entry_fsm #(.NDIGITS(ND)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         kv;
    logic [3:0]   key;
    logic         kt;
    logic         rv;
    logic [W-1:0] res;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic [1:0]   e_op;
    logic         e_start;
    logic [W-1:0] e_disp;
    logic [1:0]   e_st;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic kv, input logic [3:0] key,
                   input logic kt, input logic rv, input logic [W-1:0] res,
                   input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                   input logic st, input logic [W-1:0] disp, input logic [1:0] s);
    vec_t t;
    t.rst = rst; t.kv = kv; t.key = key; t.kt = kt; t.rv = rv; t.res = res;
    t.e_a = a; t.e_b = b; t.e_op = op; t.e_start = st; t.e_disp = disp; t.e_st = s;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic rst, input logic kv, input logic [3:0] key,
                       input logic kt, input logic rv, input logic [W-1:0] res);
    @(negedge clock);
    reset            = rst;
    bus.key_valid    = kv;
    bus.key          = key;
    bus.keytype      = kt;
    bus.result_valid = rv;
    bus.result_bcd   = res;
    @(posedge clock);
    #1;
    reset            = 1'b0;
    bus.key_valid    = 1'b0;
    bus.result_valid = 1'b0;
  endtask

  task automatic dig(input logic [3:0] k);  cycle(1'b0, 1'b1, k, 1'b1, 1'b0, '0); endtask
  task automatic sym(input logic [3:0] k);  cycle(1'b0, 1'b1, k, 1'b0, 1'b0, '0); endtask

  task automatic chk_all(input string tag, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] op,
                         input logic st, input logic [W-1:0] disp, input logic [1:0] s);
    chk({tag, ".operand_a"},   idx, 32'(bus.operand_a),   32'(a));
    chk({tag, ".operand_b"},   idx, 32'(bus.operand_b),   32'(b));
    chk({tag, ".op"},          idx, 32'(bus.op),          32'(op));
    chk({tag, ".calc_start"},  idx, 32'(bus.calc_start),  32'(st));
    chk({tag, ".display_bcd"}, idx, 32'(bus.display_bcd), 32'(disp));
    chk({tag, ".state_dbg"},   idx, 32'(bus.state_dbg),   32'(s));
  endtask

  initial begin
    int pulses;
    reset            = 1'b1;
    bus.key_valid    = 1'b0;
    bus.key          = '0;
    bus.keytype      = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_bcd   = '0;

    //  rst kv key   kt rv res       a        b        op st disp     state
    v(1, 0, 4'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 0 reset
    v(0, 1, 4'h1, 1, 0, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h0001, 2'b00); // 1
    v(0, 1, 4'h2, 1, 0, 16'h0000, 16'h0012, 16'h0000, 0, 0, 16'h0012, 2'b00); // 2
    v(0, 1, 4'h3, 1, 0, 16'h0000, 16'h0123, 16'h0000, 0, 0, 16'h0123, 2'b00); // 3
    v(0, 1, 4'h4, 1, 0, 16'h0000, 16'h1234, 16'h0000, 0, 0, 16'h1234, 2'b00); // 4
    v(0, 1, 4'h5, 1, 0, 16'h0000, 16'h1234, 16'h0000, 0, 0, 16'h1234, 2'b00); // 5 fifth digit dropped
    v(0, 1, 4'hF, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 6 clear
    v(0, 1, 4'h7, 1, 0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 16'h0007, 2'b00); // 7
    v(0, 1, 4'hA, 0, 0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 16'h0007, 2'b01); // 8 +
    v(0, 1, 4'hE, 0, 0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 16'h0007, 2'b01); // 9 = with no B
    v(0, 1, 4'hB, 0, 0, 16'h0000, 16'h0007, 16'h0000, 1, 0, 16'h0007, 2'b01); // 10 op replace
    v(0, 1, 4'hC, 0, 0, 16'h0000, 16'h0007, 16'h0000, 2, 0, 16'h0007, 2'b01); // 11
    v(0, 1, 4'hA, 0, 0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 16'h0007, 2'b01); // 12
    v(0, 1, 4'h3, 1, 0, 16'h0000, 16'h0007, 16'h0003, 0, 0, 16'h0003, 2'b01); // 13
    v(0, 1, 4'hE, 0, 0, 16'h0000, 16'h0007, 16'h0003, 0, 1, 16'h0003, 2'b10); // 14 start
    v(0, 0, 4'h0, 0, 0, 16'h0000, 16'h0007, 16'h0003, 0, 0, 16'h0003, 2'b10); // 15 pulse ends
    v(0, 1, 4'h5, 1, 0, 16'h0000, 16'h0007, 16'h0003, 0, 0, 16'h0003, 2'b10); // 16 key in WAIT
    v(0, 0, 4'h0, 0, 1, 16'h0010, 16'h0007, 16'h0003, 0, 0, 16'h0010, 2'b11); // 17 result
    v(0, 1, 4'hE, 0, 0, 16'h0000, 16'h0007, 16'h0003, 0, 0, 16'h0010, 2'b11); // 18 = in SHOW
    v(0, 1, 4'hD, 0, 0, 16'h0000, 16'h0010, 16'h0000, 3, 0, 16'h0010, 2'b01); // 19 chain /
    v(0, 1, 4'h2, 1, 0, 16'h0000, 16'h0010, 16'h0002, 3, 0, 16'h0002, 2'b01); // 20
    v(0, 1, 4'hB, 1, 0, 16'h0000, 16'h0010, 16'h0002, 3, 0, 16'h0002, 2'b01); // 21 bad keytype
    v(0, 1, 4'hE, 0, 0, 16'h0000, 16'h0010, 16'h0002, 3, 1, 16'h0002, 2'b10); // 22 start
    v(0, 0, 4'h0, 0, 1, 16'h0005, 16'h0010, 16'h0002, 3, 0, 16'h0005, 2'b11); // 23 result
    v(0, 1, 4'h9, 1, 0, 16'h0000, 16'h0009, 16'h0000, 3, 0, 16'h0009, 2'b00); // 24 new entry
    v(0, 0, 4'h0, 0, 1, 16'h0099, 16'h0009, 16'h0000, 3, 0, 16'h0009, 2'b00); // 25 stray result
    v(0, 1, 4'hC, 0, 0, 16'h0000, 16'h0009, 16'h0000, 2, 0, 16'h0009, 2'b01); // 26
    v(0, 1, 4'h4, 1, 0, 16'h0000, 16'h0009, 16'h0004, 2, 0, 16'h0004, 2'b01); // 27
    v(0, 1, 4'hE, 0, 0, 16'h0000, 16'h0009, 16'h0004, 2, 1, 16'h0004, 2'b10); // 28
    v(0, 1, 4'hF, 0, 1, 16'h0077, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 29 clear beats result
    v(0, 0, 4'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 30
    v(0, 1, 4'h8, 1, 0, 16'h0000, 16'h0008, 16'h0000, 0, 0, 16'h0008, 2'b00); // 31
    v(0, 1, 4'hA, 0, 0, 16'h0000, 16'h0008, 16'h0000, 0, 0, 16'h0008, 2'b01); // 32
    v(0, 1, 4'h6, 1, 0, 16'h0000, 16'h0008, 16'h0006, 0, 0, 16'h0006, 2'b01); // 33
    v(1, 0, 4'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 34 reset mid-B
    v(0, 0, 4'h0, 0, 1, 16'h0042, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00); // 35 result dropped

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].kv, vecs[i].key, vecs[i].kt, vecs[i].rv, vecs[i].res);
      chk_all("vec", i, vecs[i].e_a, vecs[i].e_b, vecs[i].e_op, vecs[i].e_start,
              vecs[i].e_disp, vecs[i].e_st);
    end

    // calc_start must pulse exactly once while the FSM idles in WAIT.
    dig(4'h1); sym(4'hA); dig(4'h2); sym(4'hE);
    pulses = int'(bus.calc_start);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, '0);
      pulses += int'(bus.calc_start);
    end
    chk("seq.start_pulses", 100, 32'(pulses), 32'd1);
    chk("seq.wait_hold", 100, 32'(bus.state_dbg), 32'd2);

    // Full-width result chains into A; B entry then proceeds normally.
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h1234);
    chk_all("seq.show", 101, 16'h0001, 16'h0002, 2'd0, 1'b0, 16'h1234, 2'b11);
    sym(4'hB);
    chk_all("seq.chain", 102, 16'h1234, 16'h0000, 2'd1, 1'b0, 16'h1234, 2'b01);
    dig(4'h5); dig(4'h0);
    chk_all("seq.b_entry", 103, 16'h1234, 16'h0050, 2'd1, 1'b0, 16'h0050, 2'b01);
    sym(4'hA);
    chk("seq.op_locked", 104, 32'(bus.op), 32'd1);
    sym(4'hE);
    chk("seq.start2", 105, 32'(bus.calc_start), 32'd1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, '0);
    chk("seq.start2_end", 106, 32'(bus.calc_start), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
